// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Brief    : SPI mode-0 responder (CPOL=0, CPHA=0, MSB first), all pins
//             oversampled in the clk domain. Received frames are presented
//             as a one-cycle strobe; transmit bytes come from a one-entry
//             valid/ready buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int c_CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchroniser chains (bit 0 is the first stage) and edge-detect flops
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s, w_mosi_s, w_cs_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  state_t r_state, w_state_nxt;

  // The MSB of each frame lives directly in r_miso, so the transmit shifter
  // only holds the remaining DATA_W-1 bits. Likewise the receive shifter
  // holds the first DATA_W-1 bits and the last bit is taken straight from
  // the synchronised pin when the frame completes.
  logic [c_CNT_W-1:0] r_bitcnt,   w_bitcnt_nxt;
  logic [DATA_W-2:0]  r_shreg_tx, w_shreg_tx_nxt;
  logic [DATA_W-2:0]  r_shreg_rx, w_shreg_rx_nxt;
  logic               r_miso,     w_miso_nxt;
  logic [DATA_W-1:0]  r_rx_data,  w_rx_data_nxt;
  logic               r_rx_valid, w_rx_valid_nxt;
  logic               r_underrun, w_underrun_nxt;
  logic [DATA_W-1:0]  r_buf,      w_buf_nxt;
  logic               r_buf_full, w_buf_full_nxt;

  logic               w_frame_load;
  logic               w_accept;
  logic [DATA_W-1:0]  w_load_val;
  logic [DATA_W-1:0]  w_rx_shifted;

  // Pin synchronisers plus one delay flop for edge detection; cs idles high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shift-register and transmit-buffer decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shreg_tx_nxt = r_shreg_tx;
    w_shreg_rx_nxt = r_shreg_rx;
    w_miso_nxt     = r_miso;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_underrun_nxt = 1'b0;
    w_frame_load   = 1'b0;
    w_load_val     = r_buf_full ? r_buf : '0;
    w_rx_shifted   = {r_shreg_rx, w_mosi_s};

    case (r_state)
      ST_IDLE: begin
        // sclk edges are ignored while deselected
        if (w_cs_fall) begin
          w_state_nxt    = ST_SHIFT;
          w_bitcnt_nxt   = '0;
          w_frame_load   = 1'b1;
          w_shreg_tx_nxt = w_load_val[DATA_W-2:0];
          w_miso_nxt     = w_load_val[DATA_W-1];
          w_underrun_nxt = ~r_buf_full;
        end
      end
      ST_SHIFT: begin
        // Deselect wins over any sclk edge seen in the same cycle
        if (w_cs_rise) begin
          w_state_nxt  = ST_IDLE;
          w_bitcnt_nxt = '0;
          w_miso_nxt   = 1'b0;
        end else if (w_sclk_rise) begin
          w_shreg_rx_nxt = w_rx_shifted[DATA_W-2:0];
          w_bitcnt_nxt   = r_bitcnt + c_CNT_W'(1);
          if (r_bitcnt == c_CNT_W'(DATA_W - 1)) begin
            w_rx_data_nxt  = w_rx_shifted;
            w_rx_valid_nxt = 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_bitcnt == c_CNT_W'(DATA_W)) begin
            // Frame boundary with cs still low: start the next frame
            w_bitcnt_nxt   = '0;
            w_frame_load   = 1'b1;
            w_shreg_tx_nxt = w_load_val[DATA_W-2:0];
            w_miso_nxt     = w_load_val[DATA_W-1];
            w_underrun_nxt = ~r_buf_full;
          end else if (r_bitcnt != '0) begin
            w_miso_nxt     = r_shreg_tx[DATA_W-2];
            w_shreg_tx_nxt = {r_shreg_tx[DATA_W-3:0], 1'b0};
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A frame load empties the buffer; an accept in the same cycle refills it
    w_accept       = tx_valid & ~r_buf_full;
    w_buf_nxt      = w_accept ? tx_data : r_buf;
    if (w_frame_load) begin
      w_buf_full_nxt = w_accept;
    end else begin
      w_buf_full_nxt = r_buf_full | w_accept;
    end
  end

  // Datapath and strobe registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitcnt   <= '0;
      r_shreg_tx <= '0;
      r_shreg_rx <= '0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_bitcnt   <= w_bitcnt_nxt;
      r_shreg_tx <= w_shreg_tx_nxt;
      r_shreg_rx <= w_shreg_rx_nxt;
      r_miso     <= w_miso_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_underrun <= w_underrun_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_full <= w_buf_full_nxt;
    end
  end

  assign spi_miso    = r_miso;
  assign tx_ready    = ~r_buf_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign busy        = (r_state == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Brief    : Self-checking bench for spi_slave: a mode-0 master model at
//             clk/16, a transaction-level reference model and a scoreboard
//             monitor for received frames and underrun strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic              clk;
  logic              resetn;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_cs;
  logic              spi_miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: bytes handed to the slave but not yet sent, frames
  // whose received byte is still awaited, and underrun strobes owed.
  logic [7:0] tx_model[$];
  logic [7:0] exp_rx[$];
  int         underrun_pending = 0;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_cs      (spi_cs),
    .spi_miso    (spi_miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rx_valid / tx_underrun strobe is matched
  // against what the reference model said should happen.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (resetn) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL rx_unexpected: got rx_valid with rx_data 0x%0h, expected no strobe", rx_data);
        end else begin
          e = exp_rx.pop_front();
          chk("rx_data", rx_data, e);
        end
      end
      if (tx_underrun) begin
        chk("tx_underrun_expected", (underrun_pending > 0), 1);
        if (underrun_pending > 0) underrun_pending--;
      end
    end
  end

  task automatic load_tx(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_model.push_back(d);
  endtask

  // What the slave should shift out in a frame starting now
  task automatic next_expect(output logic [7:0] em);
    if (tx_model.size() > 0) begin
      em = tx_model.pop_front();
    end else begin
      em = 8'h00;
      underrun_pending++;
    end
  endtask

  task automatic start_frame(output logic [7:0] em);
    next_expect(em);
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Clocks nbits bits MSB first; leaves spi_clk high after the last rise
  task automatic frame_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) spi_clk = 1'b0;
      spi_mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      mi[7-i] = spi_miso;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  // Deselect before the final clock fall so no frame reload happens
  task automatic end_frame();
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic full_frame(input logic [7:0] mo, input string name);
    logic [7:0] em, got;
    start_frame(em);
    chk({name, "_busy"}, busy, 1);
    exp_rx.push_back(mo);
    frame_bits(mo, 8, got);
    end_frame();
    chk({name, "_miso"}, got, em);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && (exp_rx.size() != 0 || underrun_pending != 0); t++)
      @(negedge clk);
    chk({name, "_rx_left"}, exp_rx.size(), 0);
    chk({name, "_underrun_left"}, underrun_pending, 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_miso"},     spi_miso,    0);
    chk({name, "_tx_ready"}, tx_ready,    1);
    chk({name, "_rx_data"},  rx_data,     0);
    chk({name, "_rx_valid"}, rx_valid,    0);
    chk({name, "_underrun"}, tx_underrun, 0);
    chk({name, "_busy"},     busy,        0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] em, got, em2, got2, r;
    resetn   = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs   = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: reset mid-run with a loaded buffer
    load_tx(8'h5A);
    chk("t1_tx_ready_full", tx_ready, 0);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("t1_rst");
    tx_model.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_tx_ready", tx_ready, 1);

    // 2: single frame with a loaded byte
    load_tx(8'hA5);
    full_frame(8'h3C, "t2");
    drain("t2");
    chk("t2_rx_hold", rx_data, 8'h3C);

    // 3: two back-to-back frames under one chip select
    load_tx(8'h12);
    start_frame(em);
    load_tx(8'h34);
    exp_rx.push_back(8'h55);
    frame_bits(8'h55, 8, got);
    spi_clk = 1'b0;
    next_expect(em2);
    exp_rx.push_back(8'hAA);
    frame_bits(8'hAA, 8, got2);
    end_frame();
    chk("t3_miso0", got, em);
    chk("t3_miso1", got2, em2);
    drain("t3");
    chk("t3_rx_hold", rx_data, 8'hAA);

    // 4: no byte loaded -> zeros out, one underrun
    full_frame(8'hFF, "t4");
    drain("t4");
    chk("t4_rx_hold", rx_data, 8'hFF);

    // 5: partial frame discarded, then a full one
    start_frame(em);
    frame_bits(8'hF0, 4, got);
    end_frame();
    drain("t5_partial");
    chk("t5_rx_kept", rx_data, 8'hFF);
    r = 8'($urandom);
    load_tx(r);
    full_frame(8'hC3, "t5");
    drain("t5");
    chk("t5_rx_hold", rx_data, 8'hC3);

    // 6: reset in the middle of bit 5, then a clean frame
    load_tx(8'hFF);
    start_frame(em);
    r = 8'($urandom);
    fork
      frame_bits(r, 8, got);
      begin
        repeat (4 * 2 * HALF + HALF + 2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("t6_rst_miso", spi_miso, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tx_ready", tx_ready, 1);
      end
    join
    end_frame();
    resetn = 1'b1;
    tx_model.delete();
    repeat (4) @(negedge clk);
    r = 8'($urandom);
    load_tx(r);
    full_frame(8'h81, "t6");
    drain("t6");
    chk("t6_rx_hold", rx_data, 8'h81);

    // Randomised frames, buffer loaded about half the time
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      r = 8'($urandom);
      full_frame(r, "rand");
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
